// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intc_pkg
// Description : Register map, reset constants and helpers for apb_intc_nch.
// Revision    : 1.0 - initial release
// ============================================================================
package intc_pkg;

    localparam logic [7:0] INTC_STATUS    = 8'h01;
    localparam logic [7:0] INTC_CLEAR     = 8'h02;
    localparam logic [7:0] INTC_MASK      = 8'h03;
    localparam logic [7:0] INTC_THRESHOLD = 8'h04;
    localparam logic [7:0] INTC_MODE      = 8'h05;
    localparam logic [7:0] INTC_ID        = 8'h06;
    localparam logic [7:0] INTC_PRIO_BASE = 8'h10;

    // Threshold resets to all-ones (truncated to the priority width).
    localparam logic [31:0] INTC_THR_RESET  = 32'hFFFF_FFFF;
    localparam int          INTC_PRIO_RESET = 1;

    function automatic int intc_id_width(input int num_irq);
        return $clog2(num_irq + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/intc_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : intc_prio_arbiter
// Description : Combinational lowest-priority-value winner, ties to lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module intc_prio_arbiter
    import intc_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = intc_id_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0]        cand,
    input  logic [NUM_IRQ*PRIO_W-1:0] prio,
    output logic [ID_W-1:0]           win_id
);

    logic [PRIO_W-1:0] w_best;
    logic              w_found;

    // Strict less-than keeps the earliest index on equal priority.
    always_comb begin
        win_id  = '0;
        w_best  = '1;
        w_found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand[i] && (!w_found || (prio[i*PRIO_W +: PRIO_W] < w_best))) begin
                w_found = 1'b1;
                w_best  = prio[i*PRIO_W +: PRIO_W];
                win_id  = ID_W'(i + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_intc_nch.sv
`default_nettype none
// ============================================================================
// Module      : apb_intc_nch
// Description : N-source APB interrupt controller with level/edge modes,
//               synchronisers, registered priority arbiter and auto-claim ID.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_intc_nch
    import intc_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            pclk_i,
    input  logic                            rst_n_i,
    input  logic                            enable_i,
    input  logic                            psel_i,
    input  logic                            penable_i,
    input  logic                            pwrite_i,
    input  logic [31:0]                     paddr_i,
    input  logic [31:0]                     pwdata_i,
    output logic [31:0]                     prdata_o,
    output logic                            pready_o,
    output logic                            pslverr_o,
    input  logic [NUM_IRQ-1:0]              irq_trigger_i,
    output logic                            interrupt_o,
    output logic [intc_id_width(NUM_IRQ)-1:0] irq_id_o
);

    localparam int ID_W = intc_id_width(NUM_IRQ);

    logic [NUM_IRQ-1:0]        r_status, r_mask, r_mode, r_s_d;
    logic [PRIO_W-1:0]         r_thr;
    logic [PRIO_W-1:0]         r_prio [NUM_IRQ];
    logic [ID_W-1:0]           r_id;
    logic [31:0]               r_rdata;

    logic [NUM_IRQ-1:0]        w_s, w_rise, w_req, w_elig, w_claim, w_clr;
    logic [NUM_IRQ*PRIO_W-1:0] w_prio_flat;
    logic [ID_W-1:0]           w_win;
    logic [31:0]               w_rd_val;
    logic [7:0]                w_addr;
    logic                      w_mapped, w_wr, w_setup_rd;
    logic                      w_unused_pwdata;

    assign w_addr          = paddr_i[7:0];
    assign w_setup_rd      = psel_i & ~penable_i & ~pwrite_i;
    assign w_wr            = psel_i & penable_i & pwrite_i & w_mapped & enable_i;
    assign w_unused_pwdata = ^pwdata_i;

    generate
        if (SYNC_STAGES == 0) begin : g_sync_bypass
            assign w_s = irq_trigger_i;
        end else begin : g_sync
            logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge pclk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
                end else if (enable_i) begin
                    r_sync[0] <= irq_trigger_i;
                    for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_prio
            assign w_prio_flat[gi*PRIO_W +: PRIO_W] = r_prio[gi];
            assign w_elig[gi] = w_req[gi] && (r_prio[gi] != '0) && (r_prio[gi] <= r_thr);
        end
    endgenerate

    assign w_rise = w_s & ~r_s_d;
    assign w_req  = (r_mode & w_rise) | (~r_mode & w_s);

    // Address decode and read mux; anything unmapped reads as zero.
    always_comb begin
        w_mapped = 1'b0;
        w_rd_val = '0;
        if (paddr_i[31:8] == 24'd0) begin
            case (w_addr)
                INTC_STATUS:    begin w_mapped = 1'b1; w_rd_val = 32'(r_status); end
                INTC_CLEAR:     begin w_mapped = 1'b1; end
                INTC_MASK:      begin w_mapped = 1'b1; w_rd_val = 32'(r_mask);   end
                INTC_THRESHOLD: begin w_mapped = 1'b1; w_rd_val = 32'(r_thr);    end
                INTC_MODE:      begin w_mapped = 1'b1; w_rd_val = 32'(r_mode);   end
                INTC_ID:        begin w_mapped = 1'b1; w_rd_val = 32'(r_id);     end
                default: begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (w_addr == 8'(INTC_PRIO_BASE + i)) begin
                            w_mapped = 1'b1;
                            w_rd_val = 32'(r_prio[i]);
                        end
                    end
                end
            endcase
        end
    end

    // Reading ID acknowledges the winner, but only for edge-mode sources.
    always_comb begin
        w_claim = '0;
        if (psel_i && penable_i && !pwrite_i && w_mapped && (w_addr == INTC_ID)) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (r_id == ID_W'(i + 1)) w_claim[i] = r_mode[i];
            end
        end
    end

    assign w_clr = ((w_wr && (w_addr == INTC_CLEAR)) ? pwdata_i[NUM_IRQ-1:0] : '0) | w_claim;

    intc_prio_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_arb (
        .cand    (r_status & r_mask),
        .prio    (w_prio_flat),
        .win_id  (w_win)
    );

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_status <= '0;
            r_mask   <= '0;
            r_mode   <= '0;
            r_s_d    <= '0;
            r_thr    <= PRIO_W'(INTC_THR_RESET);
            r_id     <= '0;
            r_rdata  <= '0;
            for (int i = 0; i < NUM_IRQ; i++) r_prio[i] <= PRIO_W'(INTC_PRIO_RESET);
        end else if (enable_i) begin
            r_s_d    <= w_s;
            // New requests override a simultaneous clear so no edge is lost.
            r_status <= (r_status & ~w_clr) | w_elig;
            r_id     <= w_win;
            if (w_setup_rd) r_rdata <= w_rd_val;
            if (w_wr) begin
                case (w_addr)
                    INTC_MASK:      r_mask <= pwdata_i[NUM_IRQ-1:0];
                    INTC_THRESHOLD: r_thr  <= pwdata_i[PRIO_W-1:0];
                    INTC_MODE:      r_mode <= pwdata_i[NUM_IRQ-1:0];
                    default: begin
                        for (int i = 0; i < NUM_IRQ; i++) begin
                            if (w_addr == 8'(INTC_PRIO_BASE + i)) r_prio[i] <= pwdata_i[PRIO_W-1:0];
                        end
                    end
                endcase
            end
        end
    end

    assign prdata_o    = r_rdata;
    assign pready_o    = 1'b1;
    assign pslverr_o   = psel_i & penable_i & ~w_mapped;
    assign irq_id_o    = r_id;
    assign interrupt_o = (r_id != '0) & (|(r_status & r_mask));

endmodule
`default_nettype wire

// File: tb/tb_apb_intc_nch.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_intc_nch
// Description : Scoreboard bench for apb_intc_nch (8 sources, 2 sync stages).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_intc_nch;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 4;

    logic              clk = 1'b0;
    logic              rst_n, enable, psel, penable, pwrite;
    logic [31:0]       paddr, pwdata, prdata;
    logic              pready, pslverr, intr;
    logic [NUM_IRQ-1:0] irq;
    logic [ID_W-1:0]   id;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } apb_exp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            intr;
    } pin_exp_t;

    apb_exp_t q_apb [$];
    pin_exp_t q_pin [$];
    apb_exp_t m_a;
    pin_exp_t m_p;
    logic     pin_strobe = 1'b0;
    int       n_vec = 0;
    int       n_bad = 0;

    always #5 clk = ~clk;

    apb_intc_nch #(
        .NUM_IRQ     (NUM_IRQ),
        .PRIO_W      (3),
        .SYNC_STAGES (2)
    ) dut (
        .pclk_i        (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .psel_i        (psel),
        .penable_i     (penable),
        .pwrite_i      (pwrite),
        .paddr_i       (paddr),
        .pwdata_i      (pwdata),
        .prdata_o      (prdata),
        .pready_o      (pready),
        .pslverr_o     (pslverr),
        .irq_trigger_i (irq),
        .interrupt_o   (intr),
        .irq_id_o      (id)
    );

    // Monitor: pops the oldest expectation whenever the DUT shows a response.
    always @(negedge clk) begin
        if (psel && penable) begin
            if (q_apb.size() == 0) begin
                n_bad++;
                $display("FAIL apb_unexpected: access at addr=%h with nothing expected", paddr);
            end else begin
                m_a = q_apb.pop_front();
                n_vec++;
                if ((pslverr !== m_a.err) || (!m_a.wr && (prdata !== m_a.data))) begin
                    n_bad++;
                    $display("FAIL apb_%s addr=%h: got data=%h err=%b, want data=%h err=%b",
                             m_a.wr ? "wr" : "rd", m_a.addr, prdata, pslverr, m_a.data, m_a.err);
                end
            end
        end
        if (pin_strobe) begin
            if (q_pin.size() == 0) begin
                n_bad++;
                $display("FAIL pins_unexpected: strobe with nothing expected");
            end else begin
                m_p = q_pin.pop_front();
                n_vec++;
                if ((id !== m_p.id) || (intr !== m_p.intr) || (pready !== 1'b1)) begin
                    n_bad++;
                    $display("FAIL pins @%0t: got id=%0d int=%b pready=%b, want id=%0d int=%b pready=1",
                             $time, id, intr, pready, m_p.id, m_p.intr);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic err);
        apb_exp_t e;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        e.wr = 1'b1; e.addr = a; e.data = d; e.err = err;
        q_apb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] d, input logic err);
        apb_exp_t e;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        e.wr = 1'b0; e.addr = a; e.data = d; e.err = err;
        q_apb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic chk_pins(input logic [ID_W-1:0] eid, input logic eint);
        pin_exp_t e;
        e.id = eid; e.intr = eint;
        q_pin.push_back(e);
        pin_strobe = 1'b1;
        @(negedge clk); #1;
        pin_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; irq = '0;
        idle(1);
        chk_pins(0, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Reset values and decode boundaries
        apb_read(32'h01, 32'h0, 0);
        apb_read(32'h02, 32'h0, 0);
        apb_read(32'h03, 32'h0, 0);
        apb_read(32'h04, 32'h7, 0);
        apb_read(32'h05, 32'h0, 0);
        apb_read(32'h06, 32'h0, 0);
        for (int i = 0; i < NUM_IRQ; i++) apb_read(32'h10 + i, 32'h1, 0);
        apb_read(32'h00, 32'h0, 1);
        apb_read(32'h18, 32'h0, 1);
        apb_read(32'h101, 32'h0, 1);
        apb_write(32'h103, 32'hFF, 1);
        apb_write(32'h18, 32'h5, 1);
        apb_read(32'h03, 32'h0, 0);

        // Level sources, priority ordering and pin-to-ID latency
        apb_write(32'h03, 32'hFF, 0);
        apb_write(32'h13, 32'h2, 0);
        apb_write(32'h15, 32'h1, 0);
        irq[3] = 1'b1;
        idle(3);
        chk_pins(0, 0);
        idle(1);
        chk_pins(4, 1);
        irq[5] = 1'b1;
        idle(4);
        chk_pins(6, 1);
        apb_read(32'h01, 32'h28, 0);
        irq[5] = 1'b0;
        idle(3);
        apb_write(32'h02, 32'h20, 0);
        chk_pins(6, 1);
        idle(1);
        chk_pins(4, 1);
        apb_read(32'h01, 32'h08, 0);
        irq[3] = 1'b0;
        idle(3);
        apb_write(32'h02, 32'h08, 0);
        chk_pins(4, 0);
        idle(1);
        chk_pins(0, 0);

        // Edge mode pulse and auto-claim on ID read
        apb_write(32'h05, 32'h04, 0);
        irq[2] = 1'b1;
        idle(1);
        irq[2] = 1'b0;
        idle(4);
        chk_pins(3, 1);
        apb_read(32'h01, 32'h04, 0);
        apb_read(32'h06, 32'h3, 0);
        chk_pins(3, 0);
        idle(1);
        chk_pins(0, 0);
        apb_read(32'h01, 32'h00, 0);

        // Threshold gating; level source is not auto-claimed
        apb_write(32'h04, 32'h2, 0);
        apb_write(32'h11, 32'h3, 0);
        irq[1] = 1'b1;
        idle(4);
        apb_read(32'h01, 32'h00, 0);
        chk_pins(0, 0);
        apb_write(32'h11, 32'h2, 0);
        idle(2);
        chk_pins(2, 1);
        apb_read(32'h06, 32'h2, 0);
        apb_read(32'h01, 32'h02, 0);
        irq[1] = 1'b0;
        idle(3);
        apb_write(32'h02, 32'h02, 0);
        apb_write(32'h04, 32'h7, 0);
        idle(2);
        chk_pins(0, 0);

        // Edge arriving in the same cycle as its clear
        apb_write(32'h05, 32'h05, 0);
        irq[0] = 1'b1;
        idle(1);
        apb_write(32'h02, 32'h01, 0);
        apb_read(32'h01, 32'h01, 0);
        apb_write(32'h02, 32'h01, 0);
        apb_read(32'h01, 32'h00, 0);
        irq[0] = 1'b0;
        idle(3);

        // Global enable low: everything holds, errors still reported
        apb_read(32'h03, 32'hFF, 0);
        enable = 1'b0;
        apb_read(32'h18, 32'hFF, 1);
        irq[4] = 1'b1;
        idle(3);
        irq[4] = 1'b0;
        apb_write(32'h03, 32'h00, 0);
        idle(2);
        enable = 1'b1;
        idle(4);
        apb_read(32'h03, 32'hFF, 0);
        apb_read(32'h01, 32'h00, 0);

        // Asynchronous reset while an interrupt is pending
        irq[6] = 1'b1;
        idle(4);
        chk_pins(7, 1);
        rst_n = 1'b0;
        chk_pins(0, 0);
        irq[6] = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        apb_read(32'h01, 32'h00, 0);
        apb_read(32'h03, 32'h00, 0);
        apb_read(32'h05, 32'h00, 0);
        apb_read(32'h13, 32'h1, 0);
        apb_read(32'h04, 32'h7, 0);
        chk_pins(0, 0);

        idle(2);
        n_vec++;
        if ((q_apb.size() != 0) || (q_pin.size() != 0)) begin
            n_bad++;
            $display("FAIL drain: got %0d apb and %0d pin expectations left, want 0 and 0",
                     q_apb.size(), q_pin.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
